// File: rtl/bit_stuff_tx.sv
// Serial bit-stuffing transmitter: parallel words out LSB first, with a 0 forced after every RUN_MAX ones.
// Define BIT_STUFF_TX_PARITY_EN to append one even-parity bit (itself subject to stuffing) to every word.
module bit_stuff_tx #(
  parameter int DATA_W  = 8,
  parameter int RUN_MAX = 5
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready,
  output logic              Dout,
  output logic              Dout_valid,
  output logic              stuff
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int RUN_W = $clog2(RUN_MAX + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [RUN_W-1:0] RUN_TRIG = RUN_W'(RUN_MAX - 1);

`ifdef BIT_STUFF_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE, SEND, PARITY, STUFF} state_t;

  function automatic logic even_parity(input logic [DATA_W-1:0] w);
    return ^w;
  endfunction

  logic parity_q;
`else
  typedef enum logic [1:0] {IDLE, SEND, STUFF} state_t;
`endif

  // ret_q holds where a STUFF cycle resumes; IDLE there means "end of frame".
  state_t            state, state_nxt;
  state_t            ret_q, ret_nxt;
  logic [DATA_W-1:0] shift_reg;
  logic [CNT_W-1:0]  bit_cnt;
  logic [RUN_W-1:0]  run_cnt;

  logic hit_run;
  logic final_bit;
  logic frame_end;
  logic accept;

  // A 1 on the line that completes a run of RUN_MAX forces the next slot to be a stuffed 0.
  assign hit_run = Dout && (run_cnt == RUN_TRIG);

`ifdef BIT_STUFF_TX_PARITY_EN
  assign final_bit = (state == PARITY);
`else
  assign final_bit = (state == SEND) && (bit_cnt == LAST_BIT);
`endif

  assign frame_end = (final_bit && !hit_run) || ((state == STUFF) && (ret_q == IDLE));
  assign ready     = (state == IDLE) || frame_end;
  assign accept    = valid_in && ready;

  // ---- state register
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ret_q <= IDLE;
    end else begin
      state <= state_nxt;
      ret_q <= ret_nxt;
    end
  end

  // ---- next-state logic
  always_comb begin
    state_nxt = state;
    ret_nxt   = ret_q;
    case (state)
      IDLE: begin
        if (accept) state_nxt = SEND;
      end
      SEND: begin
        if (hit_run) begin
          state_nxt = STUFF;
          if (bit_cnt != LAST_BIT) ret_nxt = SEND;
`ifdef BIT_STUFF_TX_PARITY_EN
          else                     ret_nxt = PARITY;
`else
          else                     ret_nxt = IDLE;
`endif
        end else if (bit_cnt != LAST_BIT) begin
          state_nxt = SEND;
        end else begin
`ifdef BIT_STUFF_TX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = accept ? SEND : IDLE;
`endif
        end
      end
`ifdef BIT_STUFF_TX_PARITY_EN
      PARITY: begin
        if (hit_run) begin
          state_nxt = STUFF;
          ret_nxt   = IDLE;
        end else begin
          state_nxt = accept ? SEND : IDLE;
        end
      end
`endif
      STUFF: begin
        if (ret_q == IDLE) state_nxt = accept ? SEND : IDLE;
        else               state_nxt = ret_q;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- output decode (Moore on registered state)
  always_comb begin
    Dout       = 1'b0;
    Dout_valid = 1'b0;
    stuff      = 1'b0;
    case (state)
      SEND: begin
        Dout       = shift_reg[0];
        Dout_valid = 1'b1;
      end
`ifdef BIT_STUFF_TX_PARITY_EN
      PARITY: begin
        Dout       = parity_q;
        Dout_valid = 1'b1;
      end
`endif
      STUFF: begin
        Dout_valid = 1'b1;
        stuff      = 1'b1;
      end
      default: ;
    endcase
  end

  // ---- shift register, bit position and run tracking
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
`ifdef BIT_STUFF_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else if (accept) begin
      shift_reg <= data_in;
      bit_cnt   <= '0;
`ifdef BIT_STUFF_TX_PARITY_EN
      parity_q  <= even_parity(data_in);
`endif
    end else if (state == SEND) begin
      shift_reg <= shift_reg >> 1;
      if (bit_cnt != LAST_BIT) bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

  // The run survives word boundaries; only a transmitted 0 or a return to IDLE clears it.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      run_cnt <= '0;
    end else if (state_nxt == IDLE) begin
      run_cnt <= '0;
    end else if (state == STUFF) begin
      run_cnt <= '0;
    end else if (Dout_valid) begin
      run_cnt <= Dout ? run_cnt + RUN_W'(1) : '0;
    end
  end

endmodule

// File: tb/tb_bit_stuff_tx.sv
// Bench for bit_stuff_tx: directed words plus random bursts checked against a bit-list stuffing model.
module tb_bit_stuff_tx;

  localparam int DATA_W  = 8;
  localparam int RUN_MAX = 5;

  logic              CLK = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] data_in;
  logic              valid_in;
  logic              ready;
  logic              Dout;
  logic              Dout_valid;
  logic              stuff;

  int vectors     = 0;
  int miscompares = 0;

  logic [DATA_W-1:0] words_q[$];
  bit                exp_bit[$];
  bit                exp_stf[$];

  bit_stuff_tx #(.DATA_W(DATA_W), .RUN_MAX(RUN_MAX)) dut (
    .CLK       (CLK),
    .rst       (rst),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready     (ready),
    .Dout      (Dout),
    .Dout_valid(Dout_valid),
    .stuff     (stuff)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: flatten the burst into raw line bits, then insert a 0 after every RUN_MAX ones.
  task automatic build_model();
    bit raw[$];
    int run = 0;
    exp_bit.delete();
    exp_stf.delete();
    foreach (words_q[w]) begin
      for (int i = 0; i < DATA_W; i++) raw.push_back(words_q[w][i]);
`ifdef BIT_STUFF_TX_PARITY_EN
      raw.push_back(^words_q[w]);
`endif
    end
    foreach (raw[k]) begin
      exp_bit.push_back(raw[k]);
      exp_stf.push_back(1'b0);
      run = raw[k] ? run + 1 : 0;
      if (run == RUN_MAX) begin
        exp_bit.push_back(1'b0);
        exp_stf.push_back(1'b1);
        run = 0;
      end
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_dout"}, Dout, 0);
    chk({tag, "_dvalid"}, Dout_valid, 0);
    chk({tag, "_stuff"}, stuff, 0);
    chk({tag, "_ready"}, ready, 1);
  endtask

  // Streams words_q with valid_in held until all words are accepted; called and returns at a negedge.
  task automatic run_stream(input string tag);
    int  idx = 0, cyc = 0, ones = 0, max_ones = 0, gaps = 0;
    int  limit;
    bit  started = 0, acc_now;
    build_model();
    limit = (DATA_W + 4) * 2 * (words_q.size() + 1) + 20;
    while ((idx < words_q.size() || exp_bit.size() > 0) && cyc < limit) begin
      if (idx < words_q.size()) begin
        valid_in = 1'b1;
        data_in  = ready ? words_q[idx] : DATA_W'($urandom);
      end else begin
        valid_in = 1'b0;
        data_in  = DATA_W'($urandom);
      end
      acc_now = valid_in && ready;
      @(posedge CLK);
      if (acc_now) idx++;
      @(negedge CLK);
      cyc++;
      if (Dout_valid) begin
        started = 1;
        if (exp_bit.size() == 0) begin
          chk({tag, "_extra_bit"}, 1, 0);
        end else begin
          chk({tag, "_dout"}, Dout, exp_bit.pop_front());
          chk({tag, "_stuff"}, stuff, exp_stf.pop_front());
        end
        ones = Dout ? ones + 1 : 0;
        if (ones > max_ones) max_ones = ones;
      end else if (started && exp_bit.size() > 0) begin
        gaps++;
      end
    end
    valid_in = 1'b0;
    chk({tag, "_timeout"}, cyc < limit, 1);
    chk({tag, "_gaps"}, gaps, 0);
    chk({tag, "_accepts"}, idx, words_q.size());
    chk({tag, "_maxrun_ok"}, max_ones <= RUN_MAX, 1);
    @(negedge CLK);
    check_idle({tag, "_end"});
  endtask

  initial begin
    int n;
    logic [DATA_W-1:0] w;
    rst      = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;

    // Reset held across two edges, then three idle cycles.
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_idle("reset");
    rst = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      check_idle("idle");
    end

    words_q = '{8'hA5};          run_stream("a5");
    words_q = '{8'hFF};          run_stream("ff");
    words_q = '{8'hF0, 8'h0F};   run_stream("f0_0f");
    words_q = '{8'h07};          run_stream("h07");
    words_q = '{8'hF8};          run_stream("f8");

    // Reset during bit 3 of 8'hFF: outputs must drop without a clock edge.
    valid_in = 1'b1;
    data_in  = 8'hFF;
    @(posedge CLK);
    @(negedge CLK);
    valid_in = 1'b0;
    chk("mid_bit0", Dout, 1);
    repeat (2) @(negedge CLK);
    chk("mid_bit2", Dout_valid, 1);
    @(posedge CLK);
    #2 rst = 1'b0;
    #1 check_idle("mid_async");
    @(negedge CLK);
    check_idle("mid_held");
    rst = 1'b1;
    @(negedge CLK);
    words_q = '{8'h1F};          run_stream("post_rst_1f");

    // Random bursts, biased toward dense ones so stuffing lands at many positions.
    for (int b = 0; b < 12; b++) begin
      words_q.delete();
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        case ($urandom_range(0, 2))
          0:       w = DATA_W'($urandom);
          1:       w = DATA_W'($urandom | $urandom | $urandom);
          default: w = {DATA_W{1'b1}} ^ DATA_W'(1 << $urandom_range(0, DATA_W - 1));
        endcase
        words_q.push_back(w);
      end
      run_stream($sformatf("rand%0d", b));
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
